lcd_write_arbiter: RTL and testbench

- Shares the 4-bit LCD write path between two byte-level requesters, e.g. port 0 = config/init sequencer and port 1 = text printer.
- Arbitrates round-robin and splits each granted byte into high-then-low nibble transfers with setup, enable and hold timing.
- Enforces the inter-nibble gap and the post-byte execution gap (normal or long) before reporting completion.
- Sits directly in front of the LCD pins and replaces the per-sequencer pin drive.

---
 rtl/lcd_write_arbiter_pkg.sv | 39 +++
 rtl/lcd_nibble_writer.sv | 78 +++++++
 rtl/lcd_write_arbiter.sv | 138 +++++++++++++
 tb/tb_lcd_write_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_write_arbiter_pkg.sv
// Shared definitions for the LCD write arbiter: state encodings, default
// timing constants (50 MHz clock) and the LCD command bytes used by the sequencers.
package lcd_write_arbiter_pkg;

    // Byte-level arbiter states; the SETUP/ENABLE/HOLD phases live in the nibble writer.
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WRITE,
        ARB_NIBBLE_GAP,
        ARB_BYTE_GAP
    } arb_state_t;

    // Per-nibble phases of the E strobe.
    typedef enum logic [1:0] {
        NW_IDLE,
        NW_SETUP,
        NW_ENABLE,
        NW_HOLD
    } nw_state_t;

    localparam int unsigned DEF_SETUP_CYCLES      = 2;
    localparam int unsigned DEF_ENABLE_CYCLES     = 12;
    localparam int unsigned DEF_HOLD_CYCLES       = 1;
    localparam int unsigned DEF_NIBBLE_GAP_CYCLES = 50;
    localparam int unsigned DEF_BYTE_GAP_CYCLES   = 2000;
    localparam int unsigned DEF_LONG_GAP_CYCLES   = 82000;

    localparam logic [7:0] LCD_CMD_CLEAR        = 8'h01;
    localparam logic [7:0] LCD_CMD_RETURN_HOME  = 8'h02;
    localparam logic [7:0] LCD_CMD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] LCD_CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] LCD_CMD_FUNCTION_SET = 8'h28;

    // One-hot port vector for a single-bit port index.
    function automatic logic [1:0] port_onehot(input logic i_port);
        return i_port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one 4-bit LCD transfer: data/RS setup with E low, E high, then hold.
// A start pulse latches the nibble and RS; done pulses in the final hold cycle.
module lcd_nibble_writer
    import lcd_write_arbiter_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int unsigned ENABLE_CYCLES = DEF_ENABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [3:0] i_nibble,
    input  logic       i_rs,
    output logic       o_e,
    output logic [3:0] o_data,
    output logic       o_rs,
    output logic       o_done
);

    nw_state_t   r_state;
    nw_state_t   w_next;
    logic [31:0] r_cnt;
    logic [3:0]  r_nibble;
    logic        r_rs;
    logic        w_last;

    // Phase register, per-phase counter (cleared on every phase entry) and latched nibble/RS.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= NW_IDLE;
            r_cnt    <= '0;
            r_nibble <= '0;
            r_rs     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (i_start) begin
                r_nibble <= i_nibble;
                r_rs     <= i_rs;
            end
            if (i_start || (w_next != r_state)) begin
                r_cnt <= '0;
            end else if (r_state != NW_IDLE) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // Detects the final cycle of the current phase and picks the next phase.
    always_comb begin
        w_last = 1'b0;
        w_next = r_state;
        case (r_state)
            NW_SETUP:  w_last = (r_cnt == 32'(SETUP_CYCLES - 1));
            NW_ENABLE: w_last = (r_cnt == 32'(ENABLE_CYCLES - 1));
            NW_HOLD:   w_last = (r_cnt == 32'(HOLD_CYCLES - 1));
            default:   w_last = 1'b0;
        endcase
        if (i_start) begin
            w_next = NW_SETUP;
        end else if (w_last) begin
            case (r_state)
                NW_SETUP:  w_next = NW_ENABLE;
                NW_ENABLE: w_next = NW_HOLD;
                default:   w_next = NW_IDLE;
            endcase
        end
    end

    // E is high only in the enable phase; data is driven for the whole transfer and zero otherwise.
    always_comb begin
        o_e    = (r_state == NW_ENABLE);
        o_data = (r_state != NW_IDLE) ? r_nibble : 4'h0;
        o_rs   = r_rs;
        o_done = (r_state == NW_HOLD) && w_last;
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing the 4-bit LCD write path between two byte requesters.
// Each granted byte goes out as high then low nibble, followed by the execution gap.
module lcd_write_arbiter
    import lcd_write_arbiter_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES      = DEF_SETUP_CYCLES,
    parameter int unsigned ENABLE_CYCLES     = DEF_ENABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES       = DEF_HOLD_CYCLES,
    parameter int unsigned NIBBLE_GAP_CYCLES = DEF_NIBBLE_GAP_CYCLES,
    parameter int unsigned BYTE_GAP_CYCLES   = DEF_BYTE_GAP_CYCLES,
    parameter int unsigned LONG_GAP_CYCLES   = DEF_LONG_GAP_CYCLES
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] iReq_Valid,
    input  logic [7:0] iReq_Byte0,
    input  logic [7:0] iReq_Byte1,
    input  logic [1:0] iReq_RS,
    input  logic [1:0] iReq_Long,
    output logic [1:0] oReq_Accept,
    output logic [1:0] oReq_Done,
    output logic       oBusy,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data
);

    arb_state_t  r_state;
    arb_state_t  w_next;
    logic [31:0] r_cnt;
    logic        r_nibSel;
    logic        r_lastGrant;
    logic [3:0]  r_lowNibble;
    logic        r_rs;
    logic        r_long;
    logic        r_port;

    logic        w_grant;
    logic        w_take;
    logic [7:0]  w_selByte;
    logic [31:0] w_gapLen;
    logic        w_gapLast;
    logic        w_nibGapLast;
    logic        w_nwStart;
    logic [3:0]  w_nwNibble;
    logic        w_nwRsIn;
    logic        w_nwE;
    logic [3:0]  w_nwData;
    logic        w_nwRsOut;
    logic        w_nwDone;

    // Grant selection and the starts of the two nibble transfers of a byte.
    always_comb begin
        w_grant      = (iReq_Valid == 2'b11) ? ~r_lastGrant : iReq_Valid[1];
        w_take       = (r_state == ARB_IDLE) && Reset && (iReq_Valid != 2'b00);
        w_selByte    = w_grant ? iReq_Byte1 : iReq_Byte0;
        w_gapLen     = r_long ? 32'(LONG_GAP_CYCLES) : 32'(BYTE_GAP_CYCLES);
        w_gapLast    = (r_cnt == w_gapLen - 32'd1);
        w_nibGapLast = (r_cnt == 32'(NIBBLE_GAP_CYCLES - 1));
        w_nwStart    = w_take || ((r_state == ARB_NIBBLE_GAP) && w_nibGapLast);
        w_nwNibble   = w_take ? w_selByte[7:4] : r_lowNibble;
        w_nwRsIn     = w_take ? iReq_RS[w_grant] : r_rs;
    end

    lcd_nibble_writer #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .ENABLE_CYCLES (ENABLE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_nibble_writer (
        .i_clk    (Clock),
        .i_rst_n  (Reset),
        .i_start  (w_nwStart),
        .i_nibble (w_nwNibble),
        .i_rs     (w_nwRsIn),
        .o_e      (w_nwE),
        .o_data   (w_nwData),
        .o_rs     (w_nwRsOut),
        .o_done   (w_nwDone)
    );

    // State register, gap counter cleared on every state entry, and the latched request.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ARB_IDLE;
            r_cnt       <= '0;
            r_nibSel    <= 1'b0;
            r_lastGrant <= 1'b1;
            r_lowNibble <= '0;
            r_rs        <= 1'b0;
            r_long      <= 1'b0;
            r_port      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state != ARB_IDLE) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_take) begin
                r_lowNibble <= w_selByte[3:0];
                r_rs        <= iReq_RS[w_grant];
                r_long      <= iReq_Long[w_grant];
                r_port      <= w_grant;
                r_lastGrant <= w_grant;
                r_nibSel    <= 1'b0;
            end else if ((r_state == ARB_WRITE) && w_nwDone) begin
                r_nibSel <= 1'b1;
            end
        end
    end

    // Byte sequencing: write high nibble, gap, write low nibble, execution gap.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE:       if (w_take) w_next = ARB_WRITE;
            ARB_WRITE:      if (w_nwDone) w_next = r_nibSel ? ARB_BYTE_GAP : ARB_NIBBLE_GAP;
            ARB_NIBBLE_GAP: if (w_nibGapLast) w_next = ARB_WRITE;
            ARB_BYTE_GAP:   if (w_gapLast) w_next = ARB_IDLE;
            default:        w_next = ARB_IDLE;
        endcase
    end

    // Handshake pulses and LCD pins; RS stays at the last latched value outside a transfer.
    always_comb begin
        oReq_Accept             = w_take ? port_onehot(w_grant) : 2'b00;
        oReq_Done               = ((r_state == ARB_BYTE_GAP) && w_gapLast) ? port_onehot(r_port) : 2'b00;
        oBusy                   = (r_state != ARB_IDLE);
        oLCD_Enabled            = w_nwE;
        oLCD_RegisterSelect     = (r_state == ARB_WRITE) ? w_nwRsOut : r_rs;
        oLCD_Data               = w_nwData;
        oLCD_ReadWrite          = 1'b0;
        oLCD_StrataFlashControl = 1'b1;
    end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Self-checking bench for lcd_write_arbiter: a directed byte table, hand-written
// arbitration and reset sequences, and randomized traffic, all compared against a
// timeline model that predicts every output from the byte's offset since Accept.
module tb_lcd_write_arbiter;
   import lcd_write_arbiter_pkg::*;

   localparam int S  = 2;
   localparam int EN = 12;
   localparam int H  = 1;
   localparam int N  = 50;
   localparam int G  = 2000;
   localparam int L  = 8200;
   localparam int P  = S + EN + H;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] valid = 2'b00;
   logic [7:0] byte0 = 8'h00;
   logic [7:0] byte1 = 8'h00;
   logic [1:0] rs = 2'b00;
   logic [1:0] lng = 2'b00;
   logic [1:0] accept;
   logic [1:0] done;
   logic       busy;
   logic       lcdE;
   logic       lcdRs;
   logic       lcdRw;
   logic       lcdSf;
   logic [3:0] lcdData;

   int nChecks = 0;
   int nErrors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   lcd_write_arbiter #(
      .SETUP_CYCLES      (S),
      .ENABLE_CYCLES     (EN),
      .HOLD_CYCLES       (H),
      .NIBBLE_GAP_CYCLES (N),
      .BYTE_GAP_CYCLES   (G),
      .LONG_GAP_CYCLES   (L)
   ) u_dut (
      .Clock                   (clk),
      .Reset                   (rst_n),
      .iReq_Valid              (valid),
      .iReq_Byte0              (byte0),
      .iReq_Byte1              (byte1),
      .iReq_RS                 (rs),
      .iReq_Long               (lng),
      .oReq_Accept             (accept),
      .oReq_Done               (done),
      .oBusy                   (busy),
      .oLCD_Enabled            (lcdE),
      .oLCD_RegisterSelect     (lcdRs),
      .oLCD_ReadWrite          (lcdRw),
      .oLCD_StrataFlashControl (lcdSf),
      .oLCD_Data               (lcdData)
   );

   // Shared comparison: counts every check and reports each mismatch on one line.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   logic        mActive = 1'b0;
   logic        mLast = 1'b1;
   logic        mPort = 1'b0;
   logic        mRs = 1'b0;
   logic        mLong = 1'b0;
   logic [7:0]  mByte = 8'h00;
   int          mT0 = 0;
   int          mK;
   int          mEnd;
   int          mKk;
   logic        mG;
   logic [1:0]  mAcc;
   logic [1:0]  mDone;
   logic        mE;
   logic [3:0]  mD;
   logic [12:0] expV;
   logic [12:0] actV;

   // Reference timeline: every output is a function of the offset since Accept.
   always @(negedge clk) begin
      actV = {accept, done, busy, lcdE, lcdRs, lcdRw, lcdSf, lcdData};
      if (!rst_n) begin
         mActive = 1'b0;
         mLast   = 1'b1;
         mRs     = 1'b0;
         expV    = {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
      end else if (!mActive) begin
         mAcc = 2'b00;
         mG   = 1'b0;
         if (valid != 2'b00) begin
            mG = (valid == 2'b11) ? !mLast : valid[1];
            mAcc[mG] = 1'b1;
         end
         expV = {mAcc, 2'b00, 1'b0, 1'b0, mRs, 1'b0, 1'b1, 4'h0};
         if (valid != 2'b00) begin
            mActive = 1'b1;
            mT0     = cyc;
            mPort   = mG;
            mByte   = mG ? byte1 : byte0;
            mRs     = rs[mG];
            mLong   = lng[mG];
            mLast   = mG;
         end
      end else begin
         mK   = cyc - mT0;
         mEnd = 2 * P + N + (mLong ? L : G);
         mE   = 1'b0;
         mD   = 4'h0;
         if (mK >= 1 && mK <= P) begin
            mD = mByte[7:4];
            mE = (mK > S) && (mK <= S + EN);
         end else if (mK > P + N && mK <= 2 * P + N) begin
            mKk = mK - P - N;
            mD  = mByte[3:0];
            mE  = (mKk > S) && (mKk <= S + EN);
         end
         mDone = 2'b00;
         if (mK == mEnd) mDone[mPort] = 1'b1;
         expV = {2'b00, mDone, 1'b1, mE, mRs, 1'b0, 1'b1, mD};
         if (mK == mEnd) mActive = 1'b0;
      end
      checkOutput("cycle_outputs", 32'(actV), 32'(expV));
   end

   typedef struct {
      logic       port;
      logic [7:0] b;
      logic       r;
      logic       lg;
      logic [3:0] hi;
      logic [3:0] lo;
      int         len;
   } vec_t;

   vec_t vecs[4];

   // Requests one byte, scrambles the inputs right after Accept, and measures the LCD waveform.
   task automatic applyStimulus(input vec_t v);
      int t0;
      int rise;
      int pulses;
      int eCnt[2];
      logic [3:0] eData[2];
      logic rsBad;
      logic prevE;
      logic gotAcc;
      logic gotDone;
      logic [1:0] donePort;
      int doneOff;
      t0 = 0; rise = -1; pulses = 0; eCnt[0] = 0; eCnt[1] = 0;
      eData[0] = 4'h0; eData[1] = 4'h0; rsBad = 1'b0; prevE = 1'b0;
      gotAcc = 1'b0; gotDone = 1'b0; donePort = 2'b00; doneOff = -1;
      @(posedge clk); #1;
      valid[v.port] = 1'b1;
      rs[v.port]    = v.r;
      lng[v.port]   = v.lg;
      if (v.port) byte1 = v.b; else byte0 = v.b;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (accept != 2'b00) begin
            gotAcc = 1'b1;
            break;
         end
      end
      checkOutput("accept_seen", 32'(gotAcc), 32'd1);
      if (!gotAcc) begin
         valid = 2'b00;
         return;
      end
      t0 = cyc;
      checkOutput("accept_port", 32'(accept), 32'(1 << v.port));
      @(posedge clk); #1;
      valid[v.port] = 1'b0;
      rs[v.port]    = ~v.r;
      if (v.port) byte1 = ~v.b; else byte0 = ~v.b;
      for (int i = 0; i < L + 200; i++) begin
         @(negedge clk);
         if (lcdE) begin
            if (!prevE) begin
               pulses++;
               if (pulses == 1) rise = cyc - t0;
               if (pulses <= 2) eData[pulses-1] = lcdData;
            end
            if (pulses >= 1 && pulses <= 2) eCnt[pulses-1]++;
            if (lcdRs !== v.r) rsBad = 1'b1;
         end
         prevE = lcdE;
         if (done != 2'b00) begin
            gotDone  = 1'b1;
            donePort = done;
            doneOff  = cyc - t0;
            break;
         end
      end
      checkOutput("done_seen", 32'(gotDone), 32'd1);
      checkOutput("first_e_rise", 32'(rise), 32'(S + 1));
      checkOutput("e_pulses", 32'(pulses), 32'd2);
      checkOutput("e1_width", 32'(eCnt[0]), 32'(EN));
      checkOutput("e2_width", 32'(eCnt[1]), 32'(EN));
      checkOutput("high_nibble", 32'(eData[0]), 32'(v.hi));
      checkOutput("low_nibble", 32'(eData[1]), 32'(v.lo));
      checkOutput("rs_during_e", 32'(rsBad), 32'd0);
      checkOutput("done_port", 32'(donePort), 32'(1 << v.port));
      checkOutput("byte_length", 32'(doneOff + 1), 32'(v.len));
   endtask

   int accPort[4];
   int accCyc[4];
   int firstDone;
   int nAcc;
   int t0r;
   int nDone;
   logic gotIt;

   initial begin
      vecs[0] = '{port: 1'b0, b: LCD_CMD_FUNCTION_SET, r: 1'b0, lg: 1'b0, hi: 4'h2, lo: 4'h8, len: 2081};
      vecs[1] = '{port: 1'b1, b: 8'h48,                r: 1'b1, lg: 1'b0, hi: 4'h4, lo: 4'h8, len: 2081};
      vecs[2] = '{port: 1'b0, b: LCD_CMD_CLEAR,        r: 1'b0, lg: 1'b1, hi: 4'h0, lo: 4'h1, len: 8281};
      vecs[3] = '{port: 1'b1, b: 8'hA5,                r: 1'b1, lg: 1'b0, hi: 4'hA, lo: 4'h5, len: 2081};

      // Reset state, then the directed byte table.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_e", 32'(lcdE), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

      // Both ports valid from reset: grants alternate, second accept right after first Done.
      @(posedge clk); #1;
      rst_n = 1'b0;
      valid = 2'b11; byte0 = 8'h06; byte1 = 8'h41; rs = 2'b10; lng = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      nAcc = 0; firstDone = -1;
      for (int i = 0; i < 4 * 2081 + 100 && nAcc < 4; i++) begin
         @(negedge clk);
         if (done != 2'b00 && firstDone < 0) firstDone = cyc;
         if (accept != 2'b00) begin
            accPort[nAcc] = accept[1] ? 1 : 0;
            accCyc[nAcc]  = cyc;
            nAcc++;
         end
      end
      checkOutput("alt_accepts", 32'(nAcc), 32'd4);
      for (int i = 0; i < nAcc; i++) checkOutput("alt_order", 32'(accPort[i]), 32'(i % 2));
      if (nAcc >= 2) checkOutput("alt_back_to_back", 32'(accCyc[1]), 32'(firstDone + 1));
      @(posedge clk); #1;
      valid = 2'b00;
      gotIt = 1'b0;
      for (int i = 0; i < 2200; i++) begin
         @(negedge clk);
         if (!busy) begin
            gotIt = 1'b1;
            break;
         end
      end
      checkOutput("alt_idle", 32'(gotIt), 32'd1);

      // Reset during the second E pulse: E and Busy drop at once and no Done follows.
      @(posedge clk); #1;
      valid = 2'b01; byte0 = 8'h33; rs = 2'b00; lng = 2'b00;
      gotIt = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (accept != 2'b00) begin
            gotIt = 1'b1;
            break;
         end
      end
      checkOutput("rst_accept", 32'(gotIt), 32'd1);
      t0r = cyc;
      @(posedge clk); #1;
      valid = 2'b00;
      while (cyc - t0r < P + N + S + 5) @(negedge clk);
      checkOutput("rst_e_before", 32'(lcdE), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_e_drop", 32'(lcdE), 32'd0);
      checkOutput("rst_busy_drop", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      nDone = 0;
      for (int i = 0; i < 2200; i++) begin
         @(negedge clk);
         if (done != 2'b00) nDone++;
      end
      checkOutput("rst_no_done", 32'(nDone), 32'd0);
      applyStimulus(vecs[0]);

      // Randomized traffic checked cycle by cycle against the timeline model.
      for (int i = 0; i < 15000; i++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 3) == 0) valid = 2'($urandom);
         byte0 = 8'($urandom);
         byte1 = 8'($urandom);
         rs    = 2'($urandom);
         lng   = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      end
      @(posedge clk); #1;
      valid = 2'b00;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
